// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, status flags and an iterative
// shift-add multiplier; holds one result until the consumer takes it.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             neg
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic {IDLE, MULT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] y_reg, ma_reg, mb_reg, acc_reg;
  logic             zero_reg, carry_reg, ovf_reg, neg_reg, out_valid_reg;
  logic [SHW-1:0]   cnt_reg;

  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_y, acc_step;
  logic             alu_c, alu_v, is_mul, accept;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign shamt    = b[SHW-1:0];
  assign is_mul   = (op == 4'b1010);
  assign accept   = in_valid && in_ready;
  assign acc_step = acc_reg + (mb_reg[0] ? ma_reg : '0);

  // A held result blocks new work unless it is drained on the same edge.
  assign in_ready  = (state_reg == IDLE) && !rst && (!out_valid_reg || out_ready);
  assign out_valid = out_valid_reg;
  assign y         = y_reg;
  assign zero      = zero_reg;
  assign carry     = carry_reg;
  assign ovf       = ovf_reg;
  assign neg       = neg_reg;

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      4'b0000: begin
        alu_y = sum_ext[WIDTH-1:0];
        alu_c = sum_ext[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: begin
        alu_y = diff_ext[WIDTH-1:0];
        alu_c = diff_ext[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0010: alu_y = a & b;
      4'b0011: alu_y = a | b;
      4'b0100: alu_y = a ^ b;
      4'b0101: alu_y = a << shamt;
      4'b0110: alu_y = a >> shamt;
      4'b0111: alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1000: alu_y = $signed(a) >>> shamt;
      4'b1001: alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && is_mul) state_next = MULT;
      MULT:    if (cnt_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      y_reg         <= '0;
      zero_reg      <= 1'b1;
      carry_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
      neg_reg       <= 1'b0;
      ma_reg        <= '0;
      mb_reg        <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == MULT) begin
        // One LSB-first shift-add step; the last step writes the result.
        acc_reg <= acc_step;
        ma_reg  <= ma_reg << 1;
        mb_reg  <= mb_reg >> 1;
        cnt_reg <= cnt_reg - 1'b1;
        if (cnt_reg == '0) begin
          y_reg         <= acc_step;
          zero_reg      <= (acc_step == '0);
          neg_reg       <= acc_step[WIDTH-1];
          carry_reg     <= 1'b0;
          ovf_reg       <= 1'b0;
          out_valid_reg <= 1'b1;
        end
      end else if (accept) begin
        if (is_mul) begin
          ma_reg        <= a;
          mb_reg        <= b;
          acc_reg       <= '0;
          cnt_reg       <= SHW'(WIDTH - 1);
          out_valid_reg <= 1'b0;
        end else begin
          y_reg         <= alu_y;
          zero_reg      <= (alu_y == '0);
          neg_reg       <= alu_y[WIDTH-1];
          carry_reg     <= alu_c;
          ovf_reg       <= alu_v;
          out_valid_reg <= 1'b1;
        end
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: reference model with result queue, directed vectors,
// timing/backpressure/reset scenarios, plus a WIDTH=16 multiply.
module tb_alu_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, y;
  logic [3:0] op;
  logic       zero, carry, ovf, neg;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, y16;
  logic [3:0]  op16;
  logic        zero16, carry16, ovf16, neg16;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .carry(carry), .ovf(ovf), .neg(neg));

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
    .y(y16), .zero(zero16), .carry(carry16), .ovf(ovf16), .neg(neg16));

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] y;
    logic z, c, v, n;
  } res_t;

  res_t exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plain-integer reference: results are computed from the arithmetic
  // meaning of each opcode, then reduced modulo 2^w.
  function automatic res_t model(input int w, input logic [3:0] opc,
                                 input longint av, input longint bv);
    longint m, sa, sb, sh, r, t;
    res_t   res;
    m  = longint'(1) << w;
    sa = (av >= m / 2) ? av - m : av;
    sb = (bv >= m / 2) ? bv - m : bv;
    sh = bv % w;
    res = '0;
    r = 0;
    case (opc)
      4'd0: begin
        r = (av + bv) % m; res.c = (av + bv) >= m;
        t = sa + sb; res.v = (t > m / 2 - 1) || (t < -(m / 2));
      end
      4'd1: begin
        r = (av - bv + m) % m; res.c = av < bv;
        t = sa - sb; res.v = (t > m / 2 - 1) || (t < -(m / 2));
      end
      4'd2: r = av & bv;
      4'd3: r = av | bv;
      4'd4: r = av ^ bv;
      4'd5: r = (av << sh) % m;
      4'd6: r = av >> sh;
      4'd7: r = (sa < sb) ? 1 : 0;
      4'd8: r = ((sa >>> sh) + m) % m;
      4'd9: r = (av < bv) ? 1 : 0;
      4'd10: r = (av * bv) % m;
      default: r = 0;
    endcase
    res.y = r[15:0];
    res.z = (r == 0);
    res.n = (r >= m / 2);
    return res;
  endfunction

  // Every cycle a result is held it must match the oldest outstanding op.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", out_valid, 0);
        end else begin
          chk("model_y", y, exp_q[0].y);
          chk("model_zero", zero, exp_q[0].z);
          chk("model_carry", carry, exp_q[0].c);
          chk("model_ovf", ovf, exp_q[0].v);
          chk("model_neg", neg, exp_q[0].n);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(8, op, a, b));
    end
  end

  // Tasks start and end #1 after a rising edge.
  task automatic issue(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv);
    in_valid = 1'b1; op = o; a = av; b = bv;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("issue_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("result_timeout", out_valid, 1);
  endtask

  task automatic run_op(input string name, input logic [3:0] o, input logic [7:0] av,
                        input logic [7:0] bv, input logic [7:0] ey, input logic ez,
                        input logic ec, input logic ev, input logic en);
    issue(o, av, bv);
    wait_out();
    chk({name, "_y"}, y, ey);
    chk({name, "_zero"}, zero, ez);
    chk({name, "_carry"}, carry, ec);
    chk({name, "_ovf"}, ovf, ev);
    chk({name, "_neg"}, neg, en);
    $display("op %s a=%02h b=%02h y=%02h z=%0b c=%0b v=%0b n=%0b", name, av, bv, y, zero, carry, ovf, neg);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; op16 = '0; a16 = '0; b16 = '0;

    chk("pin_model_add", model(8, 4'd0, 'h7F, 'h01).y, 'h80);
    chk("pin_model_sub_ovf", model(8, 4'd1, 'h80, 'h01).v, 1);
    chk("pin_model_sra", model(8, 4'd8, 'h80, 'h0B).y, 'hF0);
    chk("pin_model_mul16", model(16, 4'd10, 300, 200).y, 'hEA60);

    @(posedge clk); #1;
    @(negedge clk);
    chk("in_ready_during_rst", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_zero", zero, 1);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_neg", neg, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    run_op("add_7f_01", 4'd0, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1);
    run_op("add_ff_01", 4'd0, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0);
    run_op("sub_00_01", 4'd1, 8'h00, 8'h01, 8'hFF, 0, 1, 0, 1);
    run_op("sub_80_01", 4'd1, 8'h80, 8'h01, 8'h7F, 0, 0, 1, 0);
    run_op("slt_ff_01", 4'd7, 8'hFF, 8'h01, 8'h01, 0, 0, 0, 0);
    run_op("sltu_ff_01", 4'd9, 8'hFF, 8'h01, 8'h00, 1, 0, 0, 0);
    run_op("sra_80_0b", 4'd8, 8'h80, 8'h0B, 8'hF0, 0, 0, 0, 1);
    run_op("srl_80_03", 4'd6, 8'h80, 8'h03, 8'h10, 0, 0, 0, 0);
    run_op("sll_01_07", 4'd5, 8'h01, 8'h07, 8'h80, 0, 0, 0, 1);
    run_op("rsvd_f", 4'd15, 8'hAA, 8'h55, 8'h00, 1, 0, 0, 0);
    run_op("and_f0_3c", 4'd2, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0);
    run_op("or_f0_0f", 4'd3, 8'hF0, 8'h0F, 8'hFF, 0, 0, 0, 1);
    run_op("xor_ff_0f", 4'd4, 8'hFF, 8'h0F, 8'hF0, 0, 0, 0, 1);
    run_op("mul_10_10", 4'd10, 8'h10, 8'h10, 8'h00, 1, 0, 0, 0);

    // MUL latency: busy for WIDTH edges, result visible after edge T+8.
    issue(4'd10, 8'd13, 8'd11);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mul_busy_in_ready", in_ready, 0);
      chk("mul_busy_out_valid", out_valid, 0);
    end
    @(negedge clk);
    chk("mul_done_valid", out_valid, 1);
    chk("mul_13x11", y, 8'h8F);
    $display("op mul_13x11 y=%02h", y);
    @(posedge clk); #1;

    // Back-to-back ADDs, one per cycle.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; op = 4'd0; a = 8'(i * 17); b = 8'(i + 3);
      @(negedge clk);
      chk("b2b_in_ready", in_ready, 1);
      if (i > 0) chk("b2b_out_valid", out_valid, 1);
      $display("op b2b_add a=%02h b=%02h", a, b);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_last_y", y, 8'h5D);
    @(posedge clk); #1;

    // Backpressure: result held, new op waits, then drain+accept together.
    out_ready = 1'b0;
    in_valid = 1'b1; op = 4'd0; a = 8'h10; b = 8'h20;
    @(posedge clk); #1;
    a = 8'h01; b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_y", y, 8'h30);
      chk("hold_zero", zero, 0);
      $display("hold cycle %0d y=%02h", i, y);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_in_ready", in_ready, 1);
    chk("drain_y", y, 8'h30);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_new_valid", out_valid, 1);
    chk("drain_new_y", y, 8'h02);
    @(posedge clk); #1;

    // Reset three steps into a multiply.
    issue(4'd10, 8'd13, 8'd11);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    chk("midmul_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midmul_out_valid", out_valid, 0);
    chk("midmul_y", y, 0);
    chk("midmul_zero", zero, 1);
    chk("midmul_in_ready", in_ready, 1);
    $display("reset mid-mul out_valid=%0b y=%02h", out_valid, y);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_stale_mul", out_valid, 0);
    end
    @(posedge clk); #1;
    run_op("add_2_3", 4'd0, 8'd2, 8'd3, 8'd5, 0, 0, 0, 0);

    // WIDTH=16 multiply.
    in_valid16 = 1'b1; op16 = 4'd10; a16 = 16'd300; b16 = 16'd200;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready16) break;
    end
    chk("w16_issue_timeout", in_ready16, 1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid16) break;
    end
    chk("w16_result_timeout", out_valid16, 1);
    chk("w16_mul_y", y16, 16'hEA60);
    chk("w16_mul_model", y16, model(16, 4'd10, 300, 200).y);
    chk("w16_mul_zero", zero16, 0);
    chk("w16_mul_neg", neg16, 1);
    $display("op mul16 300x200 y=%04h", y16);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered successor of the team's 8-bit combinational ALU. It adds a configurable datapath width, valid/ready handshakes on input and output, an extended 4-bit opcode set, and an iterative multi-cycle multiplier. It also produces full status flags. It sits between the accelerator's operand-issue stage and its writeback/accumulate stage, and holds one result until the consumer accepts it.

Parameters:
WIDTH, 8, datapath width in bits (>=4, power of two).
SHW, $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0] (derived; not overridden).

Ports:
clk        input   1      rising-edge clock
rst        input   1      synchronous, active-high reset
in_valid   input   1      operand/op presented
in_ready   output  1      block can accept an operation this cycle
a          input   WIDTH  operand A
b          input   WIDTH  operand B
op         input   4      opcode
out_valid  output  1      result register holds an unconsumed result
out_ready  input   1      consumer accepts result this cycle
y          output  WIDTH  result
zero       output  1      y == 0
carry      output  1      ADD carry-out / SUB borrow; 0 otherwise
ovf        output  1      signed overflow for ADD/SUB; 0 otherwise
neg        output  1      y[WIDTH-1]

Behaviour:
- Opcodes:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SLL; 0110 SRL (logical); 0111 SLT (signed, y=1/0); 1000 SRA (arithmetic); 1001 SLTU (unsigned, y=1/0).
  - 1010 MUL: low WIDTH bits of the unsigned product.
  - 1011–1111 reserved: y=0, zero=1, other flags 0, single-cycle timing.
- Shifts use b[SHW-1:0] only; upper bits of b are ignored.
- Arithmetic is modulo 2^WIDTH.
  - ADD: carry = bit WIDTH of a+b.
  - SUB: carry = 1 when a < b unsigned (borrow).
  - ovf follows standard two's-complement rules for ADD/SUB and is 0 for all other ops.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready.
- State machine:
  - IDLE: in_ready = !out_valid || out_ready, so a result is drained and a new op accepted in the same cycle.
  - Single-cycle op accepted at edge T: y and flags are registered and out_valid=1 from edge T; the result is visible in cycle T+1. Throughput is 1 op/cycle when out_ready stays high.
  - MUL accepted at edge T: move to MULT, latch a and b, clear the accumulator, set counter=WIDTH-1, in_ready=0.
  - MULT: one shift-add step per cycle, LSB-first over b.
    - After WIDTH steps the result is written at edge T+WIDTH with out_valid=1, and the FSM returns to IDLE.
    - Accumulator is WIDTH bits; product bits above WIDTH-1 are discarded. MUL flags: zero and neg only.
- Output hold: while out_valid && !out_ready, y and all flags are stable and in_ready=0.
- out_valid falls on the edge where out_ready is high, unless a new op is accepted on that same edge.
- in_valid while in_ready=0 is ignored; the source must hold its inputs until accepted.
- Reset, on any clk edge with rst=1 and in any state including mid-MULT:
  - state=IDLE, any in-flight MUL is discarded.
  - out_valid=0, y=0, zero=1, carry=0, ovf=0, neg=0.
  - in_ready=1 in the cycle after reset deasserts.
  - in_ready=0 while rst is high.
- zero/neg are registered together with y and always describe y.
- Flag outputs are don't-care for consumers when out_valid=0, but must hold their last values.

Test Plan:
- WIDTH=8, out_ready=1. ADD a=0x7F,b=0x01 -> one cycle later out_valid=1, y=0x80, ovf=1, neg=1, carry=0, zero=0. Then ADD 0xFF+0x01 -> y=0x00, carry=1, zero=1, ovf=0.
- SUB 0x00-0x01 -> y=0xFF, carry=1, ovf=0. SUB 0x80-0x01 -> y=0x7F, ovf=1. SLT 0xFF,0x01 -> y=1. SLTU 0xFF,0x01 -> y=0.
- Shifts: SRA 0x80 by b=0x0B (uses 3) -> y=0xF0. SRL 0x80 by 3 -> y=0x10. SLL 0x01 by 7 -> y=0x80. Reserved op 1111 -> y=0, zero=1.
- MUL:
  - 13*11 accepted at edge T -> in_ready=0 for edges T+1..T+WIDTH-1; y=0x8F (143) with out_valid=1 at edge T+8.
  - 0x10*0x10 -> y=0x00, zero=1.
  - Repeat with WIDTH=16: 300*200 -> y=0xEA60.
- Back-to-back and backpressure: issue ADD every cycle with out_ready=1 -> one result per cycle, in order. Then hold out_ready=0 -> in_ready=0, y and flags stable for 5 cycles. Raise out_ready with in_valid high -> drain and accept happen on the same edge.
- Reset: assert rst for 1 cycle mid-MUL (3 steps in) -> next cycle out_valid=0, y=0, zero=1, in_ready=1, and no stale MUL result ever appears. A subsequent ADD 2+3 -> y=5.
